// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register-file size and fetch FSM states
package rf_pkg;
    localparam int REG_WIDTH = 32;
    localparam int NAME_BITS = 5;
    localparam int NUM_REGS = 1 << NAME_BITS;
    localparam logic [NAME_BITS-1:0] ZERO_REG = '0;
    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
endpackage

// File: rtl/operand_fetch_unit_if.sv
// operand_fetch_unit_if: decode, execute, writeback and register-file ports of the fetch unit
interface operand_fetch_unit_if #(
    parameter int REG_WIDTH = rf_pkg::REG_WIDTH,
    parameter int NAME_BITS = rf_pkg::NAME_BITS
);
    logic                 dec_valid;
    logic                 dec_ready;
    logic [NAME_BITS-1:0] dec_rs1;
    logic [NAME_BITS-1:0] dec_rs2;
    logic [NAME_BITS-1:0] dec_rd;
    logic                 dec_rd_en;
    logic                 op_valid;
    logic                 op_ready;
    logic [REG_WIDTH-1:0] op_a;
    logic [REG_WIDTH-1:0] op_b;
    logic [NAME_BITS-1:0] op_rd;
    logic                 op_rd_en;
    logic                 wb_valid;
    logic [NAME_BITS-1:0] wb_rd;
    logic [REG_WIDTH-1:0] wb_data;
    logic                 rf_re;
    logic [NAME_BITS-1:0] rf_rs1;
    logic [NAME_BITS-1:0] rf_rs2;
    logic [REG_WIDTH-1:0] rf_rd1;
    logic [REG_WIDTH-1:0] rf_rd2;
    logic                 rf_we;
    logic [NAME_BITS-1:0] rf_ws;
    logic [REG_WIDTH-1:0] rf_wd;
    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_en, op_ready,
               wb_valid, wb_rd, wb_data, rf_rd1, rf_rd2,
        output dec_ready, op_valid, op_a, op_b, op_rd, op_rd_en,
               rf_re, rf_rs1, rf_rs2, rf_we, rf_ws, rf_wd
    );
    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_rd_en, op_ready,
               wb_valid, wb_rd, wb_data, rf_rd1, rf_rd2,
        input  dec_ready, op_valid, op_a, op_b, op_rd, op_rd_en,
               rf_re, rf_rs1, rf_rs2, rf_we, rf_ws, rf_wd
    );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with set-wins update and writeback-aware hazard queries
module rf_scoreboard import rf_pkg::*; #(
    parameter int NAME_BITS = rf_pkg::NAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [NAME_BITS-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [NAME_BITS-1:0] clr_idx,
    input  logic [NAME_BITS-1:0] q_rs1,
    input  logic [NAME_BITS-1:0] q_rs2,
    input  logic [NAME_BITS-1:0] q_rd,
    output logic                 hz_rs1,
    output logic                 hz_rs2,
    output logic                 hz_rd
);
    localparam int N = 1 << NAME_BITS;
    logic [N-1:0] busy_q, busy_d;
    // a writeback landing this cycle already resolves the hazard
    function automatic logic hz(input logic [NAME_BITS-1:0] r);
        return (r != '0) && busy_q[r] && !(clr_en && clr_idx == r);
    endfunction
    assign hz_rs1 = hz(q_rs1);
    assign hz_rs2 = hz(q_rs2);
    assign hz_rd  = hz(q_rd);
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    end
endmodule

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: issues register-file reads for decoded instructions and hands operands to execute
module operand_fetch_unit import rf_pkg::*; #(
    parameter int REG_WIDTH = rf_pkg::REG_WIDTH,
    parameter int NAME_BITS = rf_pkg::NAME_BITS
) (
    input logic clk,
    input logic rst,
    operand_fetch_unit_if.slave bus
);
    state_t               state_q;
    logic [NAME_BITS-1:0] rs1_q, rs2_q, op_rd_q;
    logic                 op_rd_en_q, op_valid_q, byp1_q, byp2_q;
    logic [REG_WIDTH-1:0] bv1_q, bv2_q, op_a_q, op_b_q;
    logic                 accept, hz1, hz2, hzd, hit1, hit2;
    assign bus.dec_ready = !rst && state_q == IDLE && !hz1 && !hz2 && !(bus.dec_rd_en && hzd);
    assign accept = bus.dec_valid && bus.dec_ready;
    assign bus.rf_re  = accept;
    assign bus.rf_rs1 = bus.dec_rs1;
    assign bus.rf_rs2 = bus.dec_rs2;
    assign bus.rf_we  = !rst && bus.wb_valid && bus.wb_rd != ZERO_REG;
    assign bus.rf_ws  = bus.wb_rd;
    assign bus.rf_wd  = bus.wb_data;
    // the register file returns the old value on a same-edge write, so capture it here
    assign hit1 = bus.wb_valid && bus.wb_rd == bus.dec_rs1 && bus.dec_rs1 != ZERO_REG;
    assign hit2 = bus.wb_valid && bus.wb_rd == bus.dec_rs2 && bus.dec_rs2 != ZERO_REG;
    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_rd    = op_rd_q;
    assign bus.op_rd_en = op_rd_en_q;
    rf_scoreboard #(.NAME_BITS(NAME_BITS)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && bus.dec_rd_en && bus.dec_rd != ZERO_REG),
        .set_idx (bus.dec_rd),
        .clr_en  (bus.wb_valid),
        .clr_idx (bus.wb_rd),
        .q_rs1   (bus.dec_rs1),
        .q_rs2   (bus.dec_rs2),
        .q_rd    (bus.dec_rd),
        .hz_rs1  (hz1),
        .hz_rs2  (hz2),
        .hz_rd   (hzd)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            op_rd_q    <= '0;
            op_rd_en_q <= 1'b0;
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            bv1_q      <= '0;
            bv2_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    rs1_q      <= bus.dec_rs1;
                    rs2_q      <= bus.dec_rs2;
                    op_rd_q    <= bus.dec_rd;
                    op_rd_en_q <= bus.dec_rd_en;
                    byp1_q     <= hit1;
                    byp2_q     <= hit2;
                    bv1_q      <= bus.wb_data;
                    bv2_q      <= bus.wb_data;
                    state_q    <= READ;
                end
                READ: begin
                    op_a_q     <= rs1_q == ZERO_REG ? '0 : byp1_q ? bv1_q : bus.rf_rd1;
                    op_b_q     <= rs2_q == ZERO_REG ? '0 : byp2_q ? bv2_q : bus.rf_rd2;
                    op_valid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: if (bus.op_ready) begin
                    op_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: register-file model, vector table and scoreboard of expected operands
module tb_operand_fetch_unit;
    import rf_pkg::*;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        rd_en;
    } exp_t;
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        rd_en;
        logic [31:0] a, b;
    } vec_t;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t me;
    logic [31:0] rf_mem [32] = '{default: 32'h0};
    operand_fetch_unit_if bus();
    operand_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // synchronous register file: reads return the pre-write value on a same-edge write
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_ws] <= bus.rf_wd;
        if (bus.rf_re) begin
            bus.rf_rd1 <= rf_mem[bus.rf_rs1];
            bus.rf_rd2 <= rf_mem[bus.rf_rs2];
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && bus.op_valid && bus.op_ready) begin
            if (q.size() == 0) chk("unexpected_op", 32'd1, 32'd0);
            else begin
                me = q.pop_front();
                chk("sb_op_a", bus.op_a, me.a);
                chk("sb_op_b", bus.op_b, me.b);
                chk("sb_op_rd", 32'(bus.op_rd), 32'(me.rd));
                chk("sb_op_rd_en", 32'(bus.op_rd_en), 32'(me.rd_en));
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1; bus.wb_rd = r; bus.wb_data = d;
        tick;
        bus.wb_valid = 0;
    endtask
    task automatic issue(input logic [4:0] rs1, rs2, rd, input logic rd_en, input logic [31:0] ea, eb);
        int n = 0;
        bus.dec_rs1 = rs1; bus.dec_rs2 = rs2; bus.dec_rd = rd; bus.dec_rd_en = rd_en;
        bus.dec_valid = 1;
        #1;
        while (!bus.dec_ready && n < 50) begin
            tick; #1; n++;
        end
        chk("accept", 32'(bus.dec_ready), 32'd1);
        chk("rf_re", 32'(bus.rf_re), 32'd1);
        chk("rf_rs1", 32'(bus.rf_rs1), 32'(rs1));
        if (bus.dec_ready) q.push_back('{ea, eb, rd, rd_en});
        tick;
        bus.dec_valid = 0;
    endtask
    task automatic drain;
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            tick; n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        tick;
    endtask
    task automatic wait_valid;
        int n = 0;
        while (!bus.op_valid && n < 20) begin
            tick; n++;
        end
        chk("op_valid_wait", 32'(bus.op_valid), 32'd1);
    endtask
    vec_t vt[6];
    initial begin
        vt[0] = '{5'd3,  5'd5,  5'd6,  1'b1, 32'h33,   32'h55};
        vt[1] = '{5'd10, 5'd0,  5'd0,  1'b0, 32'hAAAA, 32'h0};
        vt[2] = '{5'd5,  5'd5,  5'd11, 1'b1, 32'h55,   32'h55};
        vt[3] = '{5'd1,  5'd31, 5'd12, 1'b0, 32'h5,    32'h3};
        vt[4] = '{5'd31, 5'd10, 5'd13, 1'b1, 32'h3,    32'hAAAA};
        vt[5] = '{5'd3,  5'd3,  5'd3,  1'b1, 32'h33,   32'h33};
        bus.dec_valid = 0; bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 0; bus.dec_rd_en = 0;
        bus.op_ready = 0;
        bus.wb_valid = 1; bus.wb_rd = 5'd1; bus.wb_data = 32'h99;
        #3;
        chk("rst_dec_ready", 32'(bus.dec_ready), 32'd0);
        chk("rst_rf_re", 32'(bus.rf_re), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_busy", dut.u_sb.busy_q, 32'd0);
        bus.wb_valid = 0;
        tick;
        rst = 0;
        bus.op_ready = 1;
        // basic fetch with cycle-exact latency
        wb(5'd1, 32'd5);
        wb(5'd31, 32'd3);
        issue(5'd1, 5'd31, 5'd2, 1'b1, 32'd5, 32'd3);
        chk("n1_op_valid", 32'(bus.op_valid), 32'd0);
        tick;
        chk("n2_op_valid", 32'(bus.op_valid), 32'd1);
        chk("n2_op_a", bus.op_a, 32'd5);
        chk("n2_op_b", bus.op_b, 32'd3);
        chk("n2_op_rd", 32'(bus.op_rd), 32'd2);
        chk("busy2", 32'(dut.u_sb.busy_q[2]), 32'd1);
        drain;
        wb(5'd2, 32'h22);
        // x0 is never written and never becomes busy
        bus.wb_valid = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
        #1;
        chk("x0_rf_we", 32'(bus.rf_we), 32'd0);
        tick;
        bus.wb_valid = 0;
        issue(5'd0, 5'd1, 5'd0, 1'b1, 32'd0, 32'd5);
        drain;
        chk("x0_busy", dut.u_sb.busy_q, 32'd0);
        wb(5'd3, 32'h33);
        wb(5'd5, 32'h55);
        wb(5'd10, 32'hAAAA);
        for (int i = 0; i < 6; i++)
            issue(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].rd_en, vt[i].a, vt[i].b);
        drain;
        chk("table_busy", dut.u_sb.busy_q, 32'h0000_2848);
        wb(5'd3, 32'h33);
        wb(5'd6, 32'h66);
        wb(5'd11, 32'hBB);
        wb(5'd13, 32'hDD);
        // RAW stall released by same-cycle writeback with bypass
        issue(5'd1, 5'd0, 5'd4, 1'b1, 32'd5, 32'd0);
        bus.dec_rs1 = 5'd4; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd8; bus.dec_rd_en = 1; bus.dec_valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("raw_stall", 32'(bus.dec_ready), 32'd0);
            tick;
        end
        bus.wb_valid = 1; bus.wb_rd = 5'd4; bus.wb_data = 32'h1234;
        #1;
        chk("raw_release", 32'(bus.dec_ready), 32'd1);
        chk("raw_rf_re", 32'(bus.rf_re), 32'd1);
        if (bus.dec_ready) q.push_back('{32'h1234, 32'd0, 5'd8, 1'b1});
        tick;
        bus.dec_valid = 0; bus.wb_valid = 0;
        drain;
        wb(5'd8, 32'h88);
        // backpressure holds operands stable
        bus.op_ready = 0;
        issue(5'd5, 5'd10, 5'd0, 1'b0, 32'h55, 32'hAAAA);
        wait_valid;
        for (int i = 0; i < 5; i++) begin
            chk("bp_op_valid", 32'(bus.op_valid), 32'd1);
            chk("bp_op_a", bus.op_a, 32'h55);
            chk("bp_op_b", bus.op_b, 32'hAAAA);
            chk("bp_dec_ready", 32'(bus.dec_ready), 32'd0);
            tick;
        end
        bus.op_ready = 1;
        tick;
        chk("bp_op_valid_fall", 32'(bus.op_valid), 32'd0);
        drain;
        // WAW: set wins over a same-cycle clear
        issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0);
        drain;
        chk("waw_busy_pre", 32'(dut.u_sb.busy_q[7]), 32'd1);
        bus.dec_rs1 = 0; bus.dec_rs2 = 0; bus.dec_rd = 5'd7; bus.dec_rd_en = 1; bus.dec_valid = 1;
        bus.wb_valid = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h77;
        #1;
        chk("waw_accept", 32'(bus.dec_ready), 32'd1);
        if (bus.dec_ready) q.push_back('{32'd0, 32'd0, 5'd7, 1'b1});
        tick;
        bus.dec_valid = 0; bus.wb_valid = 0;
        chk("waw_busy_post", 32'(dut.u_sb.busy_q[7]), 32'd1);
        drain;
        wb(5'd7, 32'h77);
        // asynchronous reset during HOLD
        bus.op_ready = 0;
        issue(5'd1, 5'd0, 5'd3, 1'b1, 32'd5, 32'd0);
        wait_valid;
        chk("rst_busy3_pre", 32'(dut.u_sb.busy_q[3]), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("arst_busy", dut.u_sb.busy_q, 32'd0);
        chk("arst_dec_ready", 32'(bus.dec_ready), 32'd0);
        q.delete();
        tick;
        rst = 0;
        tick;
        chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("post_rst_dec_ready", 32'(bus.dec_ready), 32'd1);
        bus.op_ready = 1;
        issue(5'd31, 5'd1, 5'd0, 1'b0, 32'd3, 32'd5);
        drain;
        chk("final_queue", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
